// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART TX line among NUM_REQ byte producers.
// Latency: ack and the start-bit falling edge appear one clock after req is sampled in IDLE.
// Backpressure: req is sampled only in IDLE; each frame holds the line for 10 (11 with parity) bit periods.
// Optional even-parity bit: define UART_TX_ARB_PARITY_EN.
module uart_tx_arbiter #(
  parameter int CLK_FRQ   = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int NUM_REQ   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic                       tx
);

  localparam int OW         = $clog2(NUM_REQ);
  localparam int BAUD_TICKS = CLK_FRQ / BAUD_RATE;
  localparam int TW         = $clog2(BAUD_TICKS);
  localparam logic [TW-1:0] TICK_LAST = TW'(BAUD_TICKS - 1);

`ifdef UART_TX_ARB_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      byte_q, byte_d;
  logic            tx_q, tx_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_q, last_d;

  logic            sel_vld;
  logic [OW-1:0]   sel_idx;
  logic [OW-1:0]   cand;
  logic [7:0]      sel_byte;
  logic            tick_end;

  assign tick_end = (timer_q == TICK_LAST);
  assign sel_byte = data[{sel_idx, 3'b000} +: 8];

  // Round-robin pick: first requester after the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = OW'((int'(last_q) + k) % NUM_REQ);
      if (!sel_vld && req[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  // Next-state and output logic: grant in IDLE, then walk start/data/(parity)/stop bit periods.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    ack_d   = '0;
    owner_d = owner_q;
    last_d  = last_q;

    // The bit timer free-runs and wraps while a frame is on the line.
    if (state_q != S_IDLE) begin
      timer_d = tick_end ? '0 : timer_q + TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        tx_d    = 1'b1;
        if (sel_vld) begin
          ack_d[sel_idx] = 1'b1;
          owner_d        = sel_idx;
          last_d         = sel_idx;
          byte_d         = sel_byte;
          bit_d          = 3'd0;
          tx_d           = 1'b0;
          state_d        = S_START;
        end
      end
      S_START: begin
        if (tick_end) begin
          tx_d    = byte_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick_end) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_ARB_PARITY_EN
            tx_d    = ^byte_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = byte_q[bit_q + 3'd1];
          end
        end
      end
`ifdef UART_TX_ARB_PARITY_EN
      S_PARITY: begin
        if (tick_end) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick_end) begin
          tx_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset abandons any frame in flight and parks the line high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 8'd0;
      tx_q    <= 1'b1;
      ack_q   <= '0;
      owner_q <= '0;
      last_q  <= OW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      ack_q   <= ack_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign tx    = tx_q;
  assign ack   = ack_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus random req/data traffic,
// compared every cycle against a frame-position reference model.
// The bit period is shrunk to 16 clocks to keep the run short.
module tb_uart_tx_arbiter;

  localparam int CLK_FRQ   = 1_600_000;
  localparam int BAUD_RATE = 100_000;
  localparam int NR        = 4;
  localparam int BT        = CLK_FRQ / BAUD_RATE;
`ifdef UART_TX_ARB_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME_BUDGET = NB * BT + 20;

  logic            clk;
  logic            reset;
  logic [NR-1:0]   req;
  logic [8*NR-1:0] data;
  logic [NR-1:0]   ack;
  logic [1:0]      owner;
  logic            busy;
  logic            tx;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit run_chk = 1'b0;

  uart_tx_arbiter #(
    .CLK_FRQ  (CLK_FRQ),
    .BAUD_RATE(BAUD_RATE),
    .NUM_REQ  (NR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .data (data),
    .ack  (ack),
    .owner(owner),
    .busy (busy),
    .tx   (tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: a frame is a bit array; m_pos counts clocks into it, -1 when idle.
  int          m_pos   = -1;
  int          m_last  = NR - 1;
  int          m_owner = 0;
  int          m_sel;
  logic [NR-1:0] m_ack = '0;
  logic [10:0] m_frame = '1;
  logic [7:0]  m_byte;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pos = -1; m_last = NR - 1; m_owner = 0; m_ack = '0;
    end else begin
      m_ack = '0;
      if (m_pos >= 0) begin
        m_pos++;
        if (m_pos == NB * BT) m_pos = -1;
      end else if (req != '0) begin
        m_sel = m_last;
        do m_sel = (m_sel + 1) % NR; while (!req[m_sel]);
        m_byte  = data[8*m_sel +: 8];
        m_frame = '1;
        m_frame[0] = 1'b0;
        for (int i = 0; i < 8; i++) m_frame[1+i] = m_byte[i];
`ifdef UART_TX_ARB_PARITY_EN
        m_frame[9] = ^m_byte;
`endif
        m_ack[m_sel] = 1'b1;
        m_owner = m_sel;
        m_last  = m_sel;
        m_pos   = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      check_eq("tx",    tx,    (m_pos < 0) ? 1'b1 : m_frame[m_pos / BT]);
      check_eq("busy",  busy,  (m_pos >= 0));
      check_eq("ack",   ack,   m_ack);
      check_eq("owner", owner, m_owner);
    end
  end

  task automatic wait_ack(output int idx, output int waited);
    idx = -1;
    waited = 0;
    while (idx < 0 && waited < FRAME_BUDGET) begin
      @(negedge clk);
      waited++;
      for (int j = 0; j < NR; j++) if (ack[j]) idx = j;
    end
    if (idx < 0) check_eq("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < FRAME_BUDGET) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_timeout", busy, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, waited, t, prev_cyc, bad;
    logic [10:0] exp_bits;
    int rr_order[5] = '{0, 1, 2, 3, 0};
    int fair_order[4] = '{1, 3, 1, 3};

    reset = 1'b0; req = '0; data = '0;
    repeat (3) @(negedge clk);
    run_chk = 1'b1;
    check_eq("rst_tx", tx, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ack", ack, 4'h0);
    check_eq("rst_owner", owner, 2'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame from requester 0, bit values sampled mid-bit.
`ifdef UART_TX_ARB_PARITY_EN
    data[7:0] = 8'h07; exp_bits = 11'h60E;
`else
    data[7:0] = 8'h55; exp_bits = 11'h2AA;
`endif
    req = 4'b0001;
    wait_ack(idx, waited);
    req = '0;
    check_eq("single_latency", waited, 1);
    check_eq("single_idx", idx, 0);
    check_eq("single_owner", owner, 2'd0);
    t = 0;
    for (int k = 0; k < NB; k++) begin
      repeat (k * BT + BT / 2 - t) @(negedge clk);
      t = k * BT + BT / 2;
      check_eq("frame_bit", tx, exp_bits[k]);
    end
    while (busy && t < FRAME_BUDGET) begin
      @(negedge clk);
      t++;
    end
    check_eq("busy_len", t, NB * BT);
    @(negedge clk);

`ifdef UART_TX_ARB_PARITY_EN
    data[7:0] = 8'h03;
    req = 4'b0001;
    wait_ack(idx, waited);
    req = '0;
    repeat (9 * BT + BT / 2) @(negedge clk);
    check_eq("parity_03", tx, 1'b0);
    wait_idle();
`endif

    // Round robin from reset with all requesters held.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    data = 32'hA3A2A1A0;
    req = 4'hF;
    prev_cyc = 0;
    for (int n = 0; n < 5; n++) begin
      wait_ack(idx, waited);
      if (n == 4) req = '0;
      check_eq("rr_order", idx, rr_order[n]);
      check_eq("rr_owner", owner, rr_order[n]);
      if (n > 0) check_eq("rr_period", cyc - prev_cyc, NB * BT + 1);
      prev_cyc = cyc;
    end
    wait_idle();

    // Fairness with only requesters 1 and 3.
    req = 4'b1010;
    for (int n = 0; n < 4; n++) begin
      wait_ack(idx, waited);
      if (n == 3) req = '0;
      check_eq("fair_order", idx, fair_order[n]);
    end
    wait_idle();

    // Reset in the middle of data bit 3, then a fresh frame.
    data[15:8] = 8'h05;
    req = 4'b0010;
    wait_ack(idx, waited);
    req = '0;
    check_eq("mid_idx", idx, 1);
    repeat (4 * BT + BT / 2) @(negedge clk);
    check_eq("pre_reset_tx", tx, 1'b0);
    #2 reset = 1'b0;
    #1;
    check_eq("async_tx", tx, 1'b1);
    check_eq("async_busy", busy, 1'b0);
    check_eq("async_ack", ack, 4'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    req = 4'b0010;
    wait_ack(idx, waited);
    req = '0;
    check_eq("post_reset_idx", idx, 1);
    check_eq("post_reset_latency", waited, 1);
    t = 0;
    while (tx == 1'b0 && t < FRAME_BUDGET) begin
      @(negedge clk);
      t++;
    end
    check_eq("start_bit_len", t, BT);
    wait_idle();

    // Long idle, then a one-clock req pulse during a frame is ignored.
    bad = 0;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      if (ack != '0 || busy || !tx) bad++;
    end
    check_eq("idle_quiet", bad, 0);
    data = $urandom;
    req = 4'b0001;
    wait_ack(idx, waited);
    repeat (3 * BT) @(negedge clk);
    req = 4'b0101;
    @(negedge clk);
    req = 4'b0001;
    wait_ack(idx, waited);
    req = '0;
    check_eq("pulse_ignored", idx, 0);
    wait_idle();

    // Random traffic, judged by the per-cycle model comparison.
    for (int n = 0; n < 8000; n++) begin
      @(negedge clk);
      data = $urandom;
      if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
    end
    req = '0;
    repeat (FRAME_BUDGET) @(negedge clk);
    check_eq("final_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
